ship_placer: RTL and testbench
==============================

Name: ship_placer

Overview:
- Write-side controller for the 12x12 two-bit board memory, which has one read/write port and uses address layout {x[7:4], y[3:0]}.
- Accepts "place ship" and "clear board" commands from game logic.
- For a placement, checks bounds and overlap by reading the board through the shared port, then writes ship cells.
- Sits between the game FSM and the slow-clock port of the board memory. Game logic never drives the memory directly.

Parameters:
- X_SIZE, 12, board columns
- Y_SIZE, 12, board rows
- X_ADDR_WIDTH, 4, x field width
- Y_ADDR_WIDTH, 4, y field width
- DATA_WIDTH, 2, cell width
- MAX_LEN, 4, longest legal ship
- LEN_WIDTH, 3, width of cmd_len

Ports:
- clk  in  1  system clock; the same clock as the memory write port
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller idle and able to accept
- cmd_clear  in  1  1 = clear whole board; x/y/len/vert ignored
- cmd_x  in  X_ADDR_WIDTH  bow column
- cmd_y  in  Y_ADDR_WIDTH  bow row
- cmd_len  in  LEN_WIDTH  ship length
- cmd_vert  in  1  0 = extends +x, 1 = extends +y
- done  out  1  one-cycle completion pulse
- status  out  2  00 OK, 01 BOUNDS, 10 OVERLAP; held until next accept
- mem_addr  out  X_ADDR_WIDTH+Y_ADDR_WIDTH  {x, y}
- mem_wdata  out  DATA_WIDTH  write data
- mem_w_nr  out  1  1 = write, 0 = read
- mem_rdata  in  DATA_WIDTH  registered read data; valid the cycle after its address

Behaviour:
- Cell codes: 00 EMPTY, 01 SHIP, 10 MISS, 11 HIT.
- Reset (async, any state): state IDLE, cmd_ready=1, done=0, status=00, mem_addr=0, mem_wdata=0, mem_w_nr=0.
- Reset mid-operation aborts immediately. Cells already written stay written; there is no rollback.
- Idle and check states always drive mem_w_nr=0. Only WRITE and CLEAR drive 1.
- Accept: cmd_valid & cmd_ready at rising edge. Call that cycle 0. Command fields are latched; cmd_ready drops in cycle 1.
- States:
  - IDLE
  - CHECK: reads issued
  - CHECK_WAIT: last read data returns
  - WRITE
  - CLEAR
  - FIN: done=1, one cycle, then IDLE
- BOUNDS rule, evaluated on the latched command in cycle 1 with L = cmd_len:
  - error if L == 0
  - error if L > MAX_LEN
  - error if end coordinate (x+L-1 or y+L-1) >= X_SIZE or >= Y_SIZE
  - compute the end coordinate at LEN_WIDTH+4 bits so it cannot wrap
- On BOUNDS error: go straight to FIN. done in cycle 1, status 01, no memory access.
- Legal placement, cell k (k = 0..L-1) = bow + k along the axis:
  - CHECK, cycles 1..L: address of cell k in cycle 1+k, mem_w_nr=0.
  - mem_rdata for cell k sampled in cycle 2+k. Cell L-1 is sampled in CHECK_WAIT (cycle L+1).
  - Any sampled value != EMPTY sets a sticky overlap flag. Remaining reads still complete.
  - If overlap: after CHECK_WAIT go to FIN. done in cycle L+2, status 10, zero writes.
  - Else WRITE, cycles L+2..2L+1: cell k written SHIP in cycle L+2+k.
  - Then FIN: done in cycle 2L+2, status 00.
  - cmd_ready=1 again from the cycle after FIN.
- CLEAR: write EMPTY to all X_SIZE*Y_SIZE cells.
  - Order: y outer, x inner, i.e. (0,0),(1,0)…(11,0),(0,1)…
  - 144 writes in cycles 1..144; done in cycle 145, status 00.
- cmd_valid while busy is ignored and not queued.
- The requester must hold the command until accepted.

Optional Feature:
- Macro: PLACER_ADJ_CHECK_EN.
- Defined: the overlap check scans the ship's bounding box grown by one cell on every side, clipped to the board.
  - Scan is row-major, one read per cycle, A = clipped box area.
  - Any non-EMPTY cell → OVERLAP, so ships may not touch, including diagonally.
  - Timing: CHECK cycles 1..A, CHECK_WAIT cycle A+1.
  - Writes in cycles A+2..A+L+1 (cell k written in cycle A+2+k); OK done in A+L+2; OVERLAP done in A+2.
- Undefined: only the L ship cells are checked, timing as above.

Test Plan:
1. Assert rst asynchronously mid-cycle → outputs go to reset values immediately; cmd_ready=1, status=00.
2. Empty board; place x=2, y=5, len=3, vert=0 →
   - reads 0x25, 0x35, 0x45 in cycles 1–3
   - writes 01 to the same addresses in cycles 5–7
   - done in cycle 8, status 00
3. After test 2, place x=3, y=4, len=2, vert=1 → reads 0x34, 0x35; 0x35 returns 01; done in cycle 4, status 10; mem_w_nr never 1.
4. Each of the following gives done in cycle 1, status 01, no memory access:
   - x=10, y=0, len=4, vert=0
   - len=0
   - len=5
   - x=0, y=9, len=4, vert=1
5. cmd_clear=1 → 144 writes of 00, first address 0x00, last 0xBB; done in cycle 145. A subsequent place of test 2 succeeds.
6. Assert rst during the 2nd WRITE cycle of a len=4 placement →
   - state returns to IDLE immediately
   - exactly the first cell remains written
   - a new command is accepted next cycle

Source files
------------

// File: rtl/ship_placer.sv
`timescale 1ns/1ps
// ship_placer: write-side controller for the 12x12 board memory.
// It accepts "place ship" and "clear board" commands. For a placement it
// checks bounds, then reads each candidate cell through the shared port to
// detect overlap, and finally writes SHIP into the ship cells.
// Optional build macro PLACER_ADJ_CHECK_EN: the overlap scan covers the
// ship's bounding box grown by one cell on every side (clipped to the board),
// so ships may not touch, including diagonally.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | cmd_ready=1, waiting for a command
// CHECK      | one read per cycle over the scan set
// CHECK_WAIT | last read data returns; decide overlap
// WRITE      | one SHIP write per cycle over the ship cells
// CLEAR      | EMPTY written to every board cell, y outer, x inner
// FIN        | done pulse for one cycle, status valid
module ship_placer #(
    parameter int X_SIZE       = 12,
    parameter int Y_SIZE       = 12,
    parameter int X_ADDR_WIDTH = 4,
    parameter int Y_ADDR_WIDTH = 4,
    parameter int DATA_WIDTH   = 2,
    parameter int MAX_LEN      = 4,
    parameter int LEN_WIDTH    = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_clear,
    input  logic [X_ADDR_WIDTH-1:0]            cmd_x,
    input  logic [Y_ADDR_WIDTH-1:0]            cmd_y,
    input  logic [LEN_WIDTH-1:0]               cmd_len,
    input  logic                               cmd_vert,
    output logic                               done,
    output logic [1:0]                         status,
    output logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_wdata,
    output logic                               mem_w_nr,
    input  logic [DATA_WIDTH-1:0]              mem_rdata
);

    // End coordinates are computed four bits wider than the length so
    // x + len - 1 can never wrap back onto the board.
    localparam int EW = LEN_WIDTH + 4;
    // Cycle counter width; must hold X_SIZE*Y_SIZE-1 for the clear sweep.
    localparam int CW = 8;

    localparam logic [DATA_WIDTH-1:0] CELL_EMPTY = '0;
    localparam logic [DATA_WIDTH-1:0] CELL_SHIP  = DATA_WIDTH'(1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BOUNDS  = 2'b01;
    localparam logic [1:0] ST_OVERLAP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_CHECK_WAIT = 3'd2,
        S_WRITE      = 3'd3,
        S_CLEAR      = 3'd4,
        S_FIN        = 3'd5
    } state_t;

    state_t                    state, state_n;
    logic [X_ADDR_WIDTH-1:0]   bow_x, bow_x_n;
    logic [Y_ADDR_WIDTH-1:0]   bow_y, bow_y_n;
    logic [LEN_WIDTH-1:0]      len_q, len_n;
    logic                      vert_q, vert_n;
    logic [X_ADDR_WIDTH-1:0]   cur_x, cur_x_n;
    logic [Y_ADDR_WIDTH-1:0]   cur_y, cur_y_n;
    logic [CW-1:0]             rem, rem_n;
    logic                      ovl, ovl_n;
    logic                      rd_pend, rd_pend_n;
    logic [1:0]                status_q, status_n;

    logic [EW-1:0]             end_x, end_y;
    logic                      bounds_err;
    logic                      hit_now;
    logic [X_ADDR_WIDTH-1:0]   scan_x0;
    logic [Y_ADDR_WIDTH-1:0]   scan_y0;
    logic [CW-1:0]             scan_cnt;

`ifdef PLACER_ADJ_CHECK_EN
    logic [X_ADDR_WIDTH-1:0]   box_xl, box_xl_n;
    logic [X_ADDR_WIDTH-1:0]   box_xh, box_xh_n;
    logic [X_ADDR_WIDTH-1:0]   ship_ex;
    logic [Y_ADDR_WIDTH-1:0]   ship_ey;
    logic [X_ADDR_WIDTH-1:0]   box_xl_c, box_xh_c;
    logic [Y_ADDR_WIDTH-1:0]   box_yl_c, box_yh_c;
`endif

    // Bounds decision on the incoming command; it is identical to the value
    // latched at accept, so the error can take effect already in cycle 1.
    always_comb begin
        end_x = EW'(cmd_x) + EW'(cmd_len) - EW'(1);
        end_y = EW'(cmd_y) + EW'(cmd_len) - EW'(1);
        bounds_err = 1'b0;
        if (cmd_len == '0)
            bounds_err = 1'b1;
        if (cmd_len > LEN_WIDTH'(MAX_LEN))
            bounds_err = 1'b1;
        // A bow off the board is rejected too: a vertical ship with x >= X_SIZE
        // would otherwise write outside the board.
        if (EW'(cmd_x) >= EW'(X_SIZE) || EW'(cmd_y) >= EW'(Y_SIZE))
            bounds_err = 1'b1;
        if (cmd_vert) begin
            if (end_y >= EW'(Y_SIZE))
                bounds_err = 1'b1;
        end else begin
            if (end_x >= EW'(X_SIZE))
                bounds_err = 1'b1;
        end
    end

    // Scan set origin and length for the overlap check.
    always_comb begin
`ifdef PLACER_ADJ_CHECK_EN
        ship_ex  = cmd_vert ? cmd_x : end_x[X_ADDR_WIDTH-1:0];
        ship_ey  = cmd_vert ? end_y[Y_ADDR_WIDTH-1:0] : cmd_y;
        box_xl_c = (cmd_x == '0) ? '0 : cmd_x - X_ADDR_WIDTH'(1);
        box_yl_c = (cmd_y == '0) ? '0 : cmd_y - Y_ADDR_WIDTH'(1);
        box_xh_c = (ship_ex >= X_ADDR_WIDTH'(X_SIZE - 1)) ?
                   X_ADDR_WIDTH'(X_SIZE - 1) : ship_ex + X_ADDR_WIDTH'(1);
        box_yh_c = (ship_ey >= Y_ADDR_WIDTH'(Y_SIZE - 1)) ?
                   Y_ADDR_WIDTH'(Y_SIZE - 1) : ship_ey + Y_ADDR_WIDTH'(1);
        scan_x0  = box_xl_c;
        scan_y0  = box_yl_c;
        scan_cnt = (CW'(box_xh_c - box_xl_c) + CW'(1)) *
                   (CW'(box_yh_c - box_yl_c) + CW'(1));
`else
        scan_x0  = cmd_x;
        scan_y0  = cmd_y;
        scan_cnt = CW'(cmd_len);
`endif
    end

    // Read data is valid the cycle after a CHECK address; flag any non-empty cell.
    assign hit_now = rd_pend && (mem_rdata != CELL_EMPTY);
    assign status  = status_q;

    // State register and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            bow_x    <= '0;
            bow_y    <= '0;
            len_q    <= '0;
            vert_q   <= 1'b0;
            cur_x    <= '0;
            cur_y    <= '0;
            rem      <= '0;
            ovl      <= 1'b0;
            rd_pend  <= 1'b0;
            status_q <= ST_OK;
`ifdef PLACER_ADJ_CHECK_EN
            box_xl   <= '0;
            box_xh   <= '0;
`endif
        end else begin
            state    <= state_n;
            bow_x    <= bow_x_n;
            bow_y    <= bow_y_n;
            len_q    <= len_n;
            vert_q   <= vert_n;
            cur_x    <= cur_x_n;
            cur_y    <= cur_y_n;
            rem      <= rem_n;
            ovl      <= ovl_n;
            rd_pend  <= rd_pend_n;
            status_q <= status_n;
`ifdef PLACER_ADJ_CHECK_EN
            box_xl   <= box_xl_n;
            box_xh   <= box_xh_n;
`endif
        end
    end

    // Next-state, datapath updates and memory port drive.
    always_comb begin
        state_n   = state;
        bow_x_n   = bow_x;
        bow_y_n   = bow_y;
        len_n     = len_q;
        vert_n    = vert_q;
        cur_x_n   = cur_x;
        cur_y_n   = cur_y;
        rem_n     = rem;
        ovl_n     = ovl | hit_now;
        rd_pend_n = (state == S_CHECK);
        status_n  = status_q;
`ifdef PLACER_ADJ_CHECK_EN
        box_xl_n  = box_xl;
        box_xh_n  = box_xh;
`endif
        mem_addr  = '0;
        mem_wdata = CELL_EMPTY;
        mem_w_nr  = 1'b0;
        cmd_ready = (state == S_IDLE);
        done      = (state == S_FIN);

        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    bow_x_n  = cmd_x;
                    bow_y_n  = cmd_y;
                    len_n    = cmd_len;
                    vert_n   = cmd_vert;
                    ovl_n    = 1'b0;
                    status_n = ST_OK;
                    if (cmd_clear) begin
                        state_n = S_CLEAR;
                        cur_x_n = '0;
                        cur_y_n = '0;
                        rem_n   = CW'(X_SIZE * Y_SIZE - 1);
                    end else if (bounds_err) begin
                        state_n  = S_FIN;
                        status_n = ST_BOUNDS;
                    end else begin
                        state_n = S_CHECK;
                        cur_x_n = scan_x0;
                        cur_y_n = scan_y0;
                        rem_n   = scan_cnt - CW'(1);
`ifdef PLACER_ADJ_CHECK_EN
                        box_xl_n = box_xl_c;
                        box_xh_n = box_xh_c;
`endif
                    end
                end
            end

            S_CHECK: begin
                mem_addr = {cur_x, cur_y};
                if (rem == '0) begin
                    state_n = S_CHECK_WAIT;
                end else begin
                    rem_n = rem - CW'(1);
`ifdef PLACER_ADJ_CHECK_EN
                    // Row-major walk of the clipped box.
                    if (cur_x == box_xh) begin
                        cur_x_n = box_xl;
                        cur_y_n = cur_y + Y_ADDR_WIDTH'(1);
                    end else begin
                        cur_x_n = cur_x + X_ADDR_WIDTH'(1);
                    end
`else
                    if (vert_q)
                        cur_y_n = cur_y + Y_ADDR_WIDTH'(1);
                    else
                        cur_x_n = cur_x + X_ADDR_WIDTH'(1);
`endif
                end
            end

            S_CHECK_WAIT: begin
                if (ovl || hit_now) begin
                    state_n  = S_FIN;
                    status_n = ST_OVERLAP;
                end else begin
                    state_n = S_WRITE;
                    cur_x_n = bow_x;
                    cur_y_n = bow_y;
                    rem_n   = CW'(len_q) - CW'(1);
                end
            end

            S_WRITE: begin
                mem_addr  = {cur_x, cur_y};
                mem_wdata = CELL_SHIP;
                mem_w_nr  = 1'b1;
                if (rem == '0) begin
                    state_n = S_FIN;
                end else begin
                    rem_n = rem - CW'(1);
                    if (vert_q)
                        cur_y_n = cur_y + Y_ADDR_WIDTH'(1);
                    else
                        cur_x_n = cur_x + X_ADDR_WIDTH'(1);
                end
            end

            S_CLEAR: begin
                mem_addr  = {cur_x, cur_y};
                mem_wdata = CELL_EMPTY;
                mem_w_nr  = 1'b1;
                if (rem == '0) begin
                    state_n = S_FIN;
                end else begin
                    rem_n = rem - CW'(1);
                    if (cur_x == X_ADDR_WIDTH'(X_SIZE - 1)) begin
                        cur_x_n = '0;
                        cur_y_n = cur_y + Y_ADDR_WIDTH'(1);
                    end else begin
                        cur_x_n = cur_x + X_ADDR_WIDTH'(1);
                    end
                end
            end

            S_FIN: begin
                state_n = S_IDLE;
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ship_placer.sv
`timescale 1ns/1ps
// Bench for ship_placer: a board-level model predicts, per command, the
// cycle-by-cycle memory port activity, done pulse, ready and status; one
// compare process checks the DUT against that prediction every cycle.
// Honours PLACER_ADJ_CHECK_EN when the design is built with it.
module tb_ship_placer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_clear, cmd_vert;
    logic [3:0] cmd_x, cmd_y;
    logic [2:0] cmd_len;
    logic       cmd_ready, done, mem_w_nr;
    logic [1:0] status, mem_wdata;
    logic [7:0] mem_addr;
    logic [1:0] mem_rdata = 2'b00;

    logic [1:0] mem [0:255] = '{default: 2'b00};

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int cyc;
        bit ca;
        int addr;
        bit w;
        int wd;
        bit d;
        bit r;
        bit cs;
        int st;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   ref_board [0:11][0:11];

`ifdef PLACER_ADJ_CHECK_EN
    localparam int T2_DONE = 20;
    localparam int T2_RD0  = 8'h14;
    localparam int T3_DONE = 14;
`else
    localparam int T2_DONE = 8;
    localparam int T2_RD0  = 8'h25;
    localparam int T3_DONE = 4;
`endif

    int t4x [4] = '{10, 0, 0, 0};
    int t4y [4] = '{0, 0, 0, 9};
    int t4l [4] = '{4, 0, 5, 4};
    bit t4v [4] = '{0, 0, 0, 1};

    always #5 clk = ~clk;

    ship_placer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_clear (cmd_clear),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_len   (cmd_len),
        .cmd_vert  (cmd_vert),
        .done      (done),
        .status    (status),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_w_nr  (mem_w_nr),
        .mem_rdata (mem_rdata)
    );

    // Board memory: one port, registered read data.
    always @(posedge clk) begin
        if (mem_w_nr)
            mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic void push(int c, bit ca, int a, bit w, int wd, bit d, bit r, bit cs, int st);
        exp_t e;
        e.cyc = c; e.ca = ca; e.addr = a; e.w = w; e.wd = wd;
        e.d = d; e.r = r; e.cs = cs; e.st = st;
        exp_q.push_back(e);
    endfunction

    // Single compare process: every predicted cycle is checked mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            cur_e = exp_q.pop_front();
            if (cur_e.ca)
                chk("mem_addr", mem_addr, cur_e.addr);
            chk("mem_w_nr", mem_w_nr, cur_e.w);
            if (cur_e.w)
                chk("mem_wdata", mem_wdata, cur_e.wd);
            chk("done", done, cur_e.d);
            chk("cmd_ready", cmd_ready, cur_e.r);
            if (cur_e.cs)
                chk("status", status, cur_e.st);
        end
    end

    // Predict the whole command from the board rules, then issue it.
    task automatic start_cmd(input bit clr, input int x, input int y, input int len, input bit vert,
                             output int done_rel, output int st, output int n_scan,
                             output int first_rd, output int first_wr, output int last_wr);
        int sx[$], sy[$], wx[$], wy[$];
        int base, ex, ey;
        bit err, ovl;
        @(negedge clk);
        base = cyc;
        first_rd = -1; first_wr = -1; last_wr = -1; n_scan = 0;
        if (clr) begin
            for (int yy = 0; yy < 12; yy++)
                for (int xx = 0; xx < 12; xx++) begin
                    push(base + 1 + yy * 12 + xx, 1, xx * 16 + yy, 1, 0, 0, 0, 0, 0);
                    ref_board[xx][yy] = 0;
                end
            first_wr = 0; last_wr = 11 * 16 + 11;
            done_rel = 145; st = 0;
        end else begin
            ex = vert ? x : x + len - 1;
            ey = vert ? y + len - 1 : y;
            err = (len == 0) || (len > 4) || (x >= 12) || (y >= 12) || (ex >= 12) || (ey >= 12);
            if (err) begin
                done_rel = 1; st = 1;
            end else begin
                for (int k = 0; k < len; k++) begin
                    wx.push_back(vert ? x : x + k);
                    wy.push_back(vert ? y + k : y);
                end
`ifdef PLACER_ADJ_CHECK_EN
                for (int yy = (y > 0 ? y - 1 : 0); yy <= (ey + 1 > 11 ? 11 : ey + 1); yy++)
                    for (int xx = (x > 0 ? x - 1 : 0); xx <= (ex + 1 > 11 ? 11 : ex + 1); xx++) begin
                        sx.push_back(xx);
                        sy.push_back(yy);
                    end
`else
                sx = wx;
                sy = wy;
`endif
                n_scan = sx.size();
                ovl = 0;
                for (int i = 0; i < n_scan; i++) begin
                    push(base + 1 + i, 1, sx[i] * 16 + sy[i], 0, 0, 0, 0, 0, 0);
                    if (ref_board[sx[i]][sy[i]] != 0)
                        ovl = 1;
                end
                first_rd = sx[0] * 16 + sy[0];
                push(base + n_scan + 1, 0, 0, 0, 0, 0, 0, 0, 0);
                if (ovl) begin
                    done_rel = n_scan + 2; st = 2;
                end else begin
                    for (int k = 0; k < len; k++) begin
                        push(base + n_scan + 2 + k, 1, wx[k] * 16 + wy[k], 1, 1, 0, 0, 0, 0);
                        ref_board[wx[k]][wy[k]] = 1;
                    end
                    first_wr = wx[0] * 16 + wy[0];
                    last_wr  = wx[len - 1] * 16 + wy[len - 1];
                    done_rel = n_scan + len + 2; st = 0;
                end
            end
        end
        push(base + done_rel, 0, 0, 0, 0, 1, 0, 1, st);
        push(base + done_rel + 1, 0, 0, 0, 0, 0, 1, 1, st);
        cmd_clear = clr;
        cmd_x     = x[3:0];
        cmd_y     = y[3:0];
        cmd_len   = len[2:0];
        cmd_vert  = vert;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            chk({name, " drain timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int dr, st, ns, frd, fwr, lwr, mism;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_vert = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_len = '0;
        for (int i = 0; i < 12; i++)
            for (int j = 0; j < 12; j++)
                ref_board[i][j] = 0;
        #3;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset done", done, 0);
        chk("reset status", status, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset mem_w_nr", mem_w_nr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Horizontal placement on an empty board.
        start_cmd(0, 2, 5, 3, 0, dr, st, ns, frd, fwr, lwr);
        chk("t2 model done cycle", dr, T2_DONE);
        chk("t2 model first read", frd, T2_RD0);
        chk("t2 model first write", fwr, 8'h25);
        chk("t2 model last write", lwr, 8'h45);
        chk("t2 model status", st, 0);
        wait_drain("t2");
        chk("t2 mem 0x35", mem[8'h35], 1);

        // Vertical placement crossing the first ship.
        start_cmd(0, 3, 4, 2, 1, dr, st, ns, frd, fwr, lwr);
        chk("t3 model done cycle", dr, T3_DONE);
        chk("t3 model status", st, 2);
        wait_drain("t3");
        chk("t3 mem 0x34 untouched", mem[8'h34], 0);

        // Legal vertical placement from the top edge.
        start_cmd(0, 8, 0, 4, 1, dr, st, ns, frd, fwr, lwr);
        wait_drain("vert");
        chk("vert mem 0x83", mem[8'h83], 1);

        // Bounds errors.
        for (int i = 0; i < 4; i++) begin
            start_cmd(0, t4x[i], t4y[i], t4l[i], t4v[i], dr, st, ns, frd, fwr, lwr);
            chk("t4 model done cycle", dr, 1);
            chk("t4 model status", st, 1);
            wait_drain("t4");
        end

        // Async reset mid-cycle while idle with a held BOUNDS status.
        @(negedge clk);
        chk("pre-reset status", status, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async rst status", status, 0);
        chk("async rst cmd_ready", cmd_ready, 1);
        chk("async rst done", done, 0);
        chk("async rst mem_w_nr", mem_w_nr, 0);
        @(negedge clk);
        rst = 1'b0;

        // Clear, then place again; a clear request while busy is ignored.
        start_cmd(1, 0, 0, 0, 0, dr, st, ns, frd, fwr, lwr);
        chk("t5 model done cycle", dr, 145);
        chk("t5 model first write", fwr, 8'h00);
        chk("t5 model last write", lwr, 8'hBB);
        wait_drain("t5 clear");
        mism = 0;
        for (int a = 0; a < 256; a++)
            if (mem[a] != 2'b00) mism++;
        chk("t5 board empty", mism, 0);
        start_cmd(0, 2, 5, 3, 0, dr, st, ns, frd, fwr, lwr);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_clear = 1'b0;
        wait_drain("t5 replace");
        chk("t5 replace mem 0x45", mem[8'h45], 1);

        // Reset during the second WRITE cycle of a len=4 placement.
        start_cmd(0, 0, 0, 4, 0, dr, st, ns, frd, fwr, lwr);
        repeat (ns + 2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t6 rst cmd_ready", cmd_ready, 1);
        chk("t6 rst mem_w_nr", mem_w_nr, 0);
        chk("t6 rst done", done, 0);
        #1 rst = 1'b0;
        for (int k = 1; k < 4; k++)
            ref_board[k][0] = 0;
        start_cmd(0, 6, 8, 2, 1, dr, st, ns, frd, fwr, lwr);
        wait_drain("t6 next");
        chk("t6 cell0 kept", mem[8'h00], 1);
        chk("t6 cell1 not written", mem[8'h10], 0);

        // Whole board against the model, including off-board addresses.
        mism = 0;
        for (int a = 0; a < 256; a++) begin
            if ((a / 16) < 12 && (a % 16) < 12) begin
                if (int'(mem[a]) != ref_board[a / 16][a % 16]) mism++;
            end else if (mem[a] != 2'b00) begin
                mism++;
            end
        end
        chk("final board", mism, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
